nave_controller: RTL and testbench
==================================

NAVE_CONTROLLER -- requirements
Module: nave_controller

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 SHALL have parameter SHIP_W, default 32, ship sprite width.
REQ-003 SHALL have parameter SHIP_Y, default 448, fixed ship row.
REQ-004 SHALL have parameter START_X, default 304, ship x after reset.
REQ-005 SHALL have parameter STEP, default 4, pixels moved per frame.
REQ-006 SHALL have parameter COOLDOWN, default 15, frames between shots.
REQ-007 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-009 SHALL have port vsync  in  1  asynchronous vertical sync from the video timing block.
REQ-010 SHALL have ports btn_left, btn_right, btn_fire  in  1 each  asynchronous, active-high player buttons.
REQ-011 SHALL have port fire_ack  in  1  shot-spawn acknowledge from the shot sprite block.
REQ-012 SHALL have ports sprite_x, sprite_y  out  10 each  ship top-left corner, fed to the ship sprite renderer.
REQ-013 SHALL have port fire_req  out  1  shot-spawn request.
REQ-014 SHALL have ports shot_x, shot_y  out  10 each  spawn coordinates, valid while fire_req=1.
REQ-015 SHALL have port frame_tick  out  1  one-cycle pulse per frame.

Function
REQ-016 SHALL pass vsync and all buttons through 2-flop synchronizers before use.
REQ-017 SHALL assert frame_tick for exactly one cycle on each falling edge of synchronized vsync.
REQ-018 SHALL update sprite_x only in the cycle after frame_tick; it SHALL hold otherwise.
REQ-019 SHALL move sprite_x by -STEP when only btn_left is pressed, +STEP when only btn_right is pressed, and hold it when both or neither are pressed.
REQ-020 SHALL compute the move in 11-bit arithmetic and clamp to [0, SCREEN_W-SHIP_W] (608 at defaults); no wrap-around.
REQ-021 SHALL drive sprite_y constantly equal to SHIP_Y.
REQ-022 SHALL implement a fire FSM with states IDLE, REQ and COOLDOWN.
REQ-023 IDLE -> REQ on a frame_tick while btn_fire is pressed; in that cycle it SHALL latch shot_x = sprite_x + SHIP_W/2 (pre-move value) and shot_y = SHIP_Y - 1.
REQ-024 SHALL hold fire_req high for the whole of REQ, with shot_x and shot_y stable.
REQ-025 REQ -> COOLDOWN on the first cycle fire_ack=1; fire_req SHALL deassert the next cycle and the frame counter SHALL load COOLDOWN.
REQ-026 SHALL ignore fire_ack outside REQ.
REQ-027 In COOLDOWN, each frame_tick SHALL decrement the counter; a frame_tick with the counter at 0 SHALL go to IDLE.
REQ-028 Holding btn_fire SHALL produce auto-fire, one request per COOLDOWN+1 frames.
REQ-029 SHALL continue ship movement unaffected in every FSM state.

Reset
REQ-030 SHALL, with reset=0 at a clock edge, set sprite_x=START_X, fire_req=0, shot_x=0, shot_y=0, frame_tick=0, FSM=IDLE, counter=0, and clear all synchronizer flops.
REQ-031 Reset asserted during REQ SHALL drop fire_req at that edge, with no acknowledge required.

Structure
REQ-032 SHALL place the screen constants (SCREEN_W, SCREEN_H=480) and the fire-FSM state encoding in the shared game package.
REQ-033 SHALL instantiate one sub-module, vsync_edge (2-flop synchronizer plus falling-edge detector), reusable by other sprite controllers.

Verification
REQ-034 The bench SHALL check: reset release -> sprite_x=304, sprite_y=448, fire_req=0.
REQ-035 The bench SHALL check: btn_right held for 80 frames from 304 -> sprite_x saturates at 608, never exceeds it, never wraps.
REQ-036 The bench SHALL check: btn_left held from sprite_x=2 -> sprite_x=0 after one frame and stays 0; both buttons held -> no change.
REQ-037 The bench SHALL check: btn_fire pulse across one vsync fall at sprite_x=100 -> fire_req=1, shot_x=116, shot_y=447, held for 5 cycles until fire_ack -> fire_req=0 the next cycle.
REQ-038 The bench SHALL check: btn_fire held continuously with immediate ack -> requests exactly 16 frames apart.
REQ-039 The bench SHALL check: reset asserted while fire_req=1 -> fire_req=0 at the next edge, FSM in IDLE, sprite_x=304.

Source files
------------

// File: rtl/nave_controller_pkg.sv
// Shared game package: screen geometry, fire-FSM encoding and the ship
// position update used by the sprite controllers.
package nave_controller_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        FIRE_IDLE     = 2'd0,
        FIRE_REQ      = 2'd1,
        FIRE_COOLDOWN = 2'd2
    } fire_state_e;

    // One frame of horizontal movement, computed 11 bits wide so a left step
    // below zero is caught as a borrow instead of wrapping.
    function automatic logic [9:0] next_ship_x(
        input logic [9:0]  x,
        input logic        left,
        input logic        right,
        input logic [10:0] step,
        input logic [10:0] max_x
    );
        logic [10:0] wide_s;
        logic [10:0] sum_s;
        logic [9:0]  res_s;
        wide_s = {1'b0, x};
        sum_s  = wide_s + step;
        res_s  = x;
        if (left && !right) begin
            if (wide_s < step) begin
                res_s = 10'd0;
            end else begin
                res_s = 10'(wide_s - step);
            end
        end else if (right && !left) begin
            if (sum_s > max_x) begin
                res_s = 10'(max_x);
            end else begin
                res_s = 10'(sum_s);
            end
        end else begin
            res_s = x;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/nave_controller_vsync_edge.sv
// Two-flop synchronizer for vertical sync plus a falling-edge detector that
// emits a registered one-cycle frame tick.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic tick_r;

    // Synchronizer chain and edge detector, all cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            meta_r <= vsync;
            sync_r <= meta_r;
            prev_r <= sync_r;
            tick_r <= prev_r & ~sync_r;
        end
    end

    assign frame_tick = tick_r;

endmodule

// File: rtl/nave_controller.sv
// Player ship controller: per-frame horizontal movement with edge clamping
// and a fire request FSM with frame-based cooldown and auto-fire.
module nave_controller #(
    parameter int SCREEN_W = nave_controller_pkg::SCREEN_W,
    parameter int SHIP_W   = 32,
    parameter int SHIP_Y   = 448,
    parameter int START_X  = 304,
    parameter int STEP     = 4,
    parameter int COOLDOWN = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       fire_ack,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       fire_req,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic       frame_tick
);

    import nave_controller_pkg::*;

    localparam logic [10:0] MAX_X_C    = 11'(SCREEN_W - SHIP_W);
    localparam logic [10:0] STEP_C     = 11'(STEP);
    localparam logic [9:0]  START_X_C  = 10'(START_X);
    localparam logic [9:0]  SHIP_Y_C   = 10'(SHIP_Y);
    localparam logic [9:0]  HALF_W_C   = 10'(SHIP_W / 2);
    localparam logic [9:0]  SHOT_Y_C   = 10'(SHIP_Y - 1);
    localparam logic [7:0]  COOLDOWN_C = 8'(COOLDOWN);

    logic [2:0]  btn_meta_r;
    logic [2:0]  btn_sync_r;
    logic        frame_tick_s;
    logic        left_s;
    logic        right_s;
    logic        fire_s;

    fire_state_e state_r;
    fire_state_e state_next_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_next_s;
    logic        latch_shot_s;
    logic        fire_req_r;
    logic [9:0]  sprite_x_r;
    logic [9:0]  shot_x_r;
    logic [9:0]  shot_y_r;

    vsync_edge u_vsync_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick_s)
    );

    // Button synchronizers: {fire, right, left}.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_meta_r <= 3'b000;
            btn_sync_r <= 3'b000;
        end else begin
            btn_meta_r <= {btn_fire, btn_right, btn_left};
            btn_sync_r <= btn_meta_r;
        end
    end

    assign left_s  = btn_sync_r[0];
    assign right_s = btn_sync_r[1];
    assign fire_s  = btn_sync_r[2];

    // Fire FSM next-state logic; an expiring cooldown with fire still held
    // re-arms on the same tick so auto-fire repeats every COOLDOWN+1 frames.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_shot_s = 1'b0;
        case (state_r)
            FIRE_IDLE: begin
                if (frame_tick_s && fire_s) begin
                    state_next_s = FIRE_REQ;
                    latch_shot_s = 1'b1;
                end else begin
                    state_next_s = FIRE_IDLE;
                end
            end
            FIRE_REQ: begin
                if (fire_ack) begin
                    state_next_s = FIRE_COOLDOWN;
                    cnt_next_s   = COOLDOWN_C;
                end else begin
                    state_next_s = FIRE_REQ;
                end
            end
            FIRE_COOLDOWN: begin
                if (frame_tick_s) begin
                    if (cnt_r == 8'd0) begin
                        if (fire_s) begin
                            state_next_s = FIRE_REQ;
                            latch_shot_s = 1'b1;
                        end else begin
                            state_next_s = FIRE_IDLE;
                        end
                    end else begin
                        cnt_next_s = cnt_r - 8'd1;
                    end
                end else begin
                    state_next_s = FIRE_COOLDOWN;
                end
            end
            default: begin
                state_next_s = FIRE_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // State, counter, request flag, shot coordinates and ship position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= FIRE_IDLE;
            cnt_r      <= 8'd0;
            fire_req_r <= 1'b0;
            shot_x_r   <= 10'd0;
            shot_y_r   <= 10'd0;
            sprite_x_r <= START_X_C;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            fire_req_r <= (state_next_s == FIRE_REQ);
            if (latch_shot_s) begin
                shot_x_r <= sprite_x_r + HALF_W_C;
                shot_y_r <= SHOT_Y_C;
            end
            if (frame_tick_s) begin
                sprite_x_r <= next_ship_x(sprite_x_r, left_s, right_s, STEP_C, MAX_X_C);
            end
        end
    end

    assign sprite_x   = sprite_x_r;
    assign sprite_y   = SHIP_Y_C;
    assign fire_req   = fire_req_r;
    assign shot_x     = shot_x_r;
    assign shot_y     = shot_y_r;
    assign frame_tick = frame_tick_s;

endmodule

// File: tb/tb_nave_controller.sv
// Directed bench for nave_controller: movement clamping, single shot,
// auto-fire cadence and reset during an outstanding request.
module tb_nave_controller;

    import nave_controller_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       fire_ack;
    logic [9:0] sprite_x, sprite_y, shot_x, shot_y;
    logic       fire_req, frame_tick;
    logic [9:0] b_sprite_x, b_sprite_y, b_shot_x, b_shot_y;
    logic       b_fire_req, b_frame_tick;

    int checks = 0;
    int errors = 0;

    nave_controller u_dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .fire_ack(fire_ack),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .fire_req(fire_req),
        .shot_x(shot_x), .shot_y(shot_y), .frame_tick(frame_tick)
    );

    // Second instance starting two pixels from the left edge.
    nave_controller #(.START_X(2)) u_dut_b (
        .clk(clk), .reset(reset), .vsync(vsync),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .fire_ack(fire_ack),
        .sprite_x(b_sprite_x), .sprite_y(b_sprite_y), .fire_req(b_fire_req),
        .shot_x(b_shot_x), .shot_y(b_shot_y), .frame_tick(b_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame();
        vsync = 1'b0;
        step(4);
        vsync = 1'b1;
        step(4);
    endtask

    task automatic do_reset();
        reset = 1'b0; vsync = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; fire_ack = 1'b0;
        step(3);
        reset = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sprite_x !== 10'd304) begin errors++; $display("FAIL reset_sprite_x got %0d want 304", sprite_x); end
        checks++; if (sprite_y !== 10'd448) begin errors++; $display("FAIL reset_sprite_y got %0d want 448", sprite_y); end
        checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL reset_fire_req got %b want 0", fire_req); end
        checks++; if (shot_x !== 10'd0 || shot_y !== 10'd0) begin errors++; $display("FAIL reset_shot got %0d,%0d want 0,0", shot_x, shot_y); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
        checks++; if (b_sprite_x !== 10'd2) begin errors++; $display("FAIL reset_b_sprite_x got %0d want 2", b_sprite_x); end
        fire_ack = 1'b1;
        step(1);
        fire_ack = 1'b0;
        step(1);
        checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored got %b want 0", fire_req); end
    endtask

    task automatic test_frame_tick();
        int pulses;
        pulses = 0;
        vsync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (frame_tick === 1'b1) pulses++;
        end
        vsync = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (frame_tick === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL frame_tick_pulses got %0d want 1", pulses); end
        checks++; if (sprite_x !== 10'd304) begin errors++; $display("FAIL idle_frame_hold got %0d want 304", sprite_x); end
    endtask

    task automatic test_right_saturate();
        int exp_x;
        btn_right = 1'b1;
        for (int i = 0; i < 80; i++) begin
            run_frame();
            exp_x = 304 + 4 * (i + 1);
            if (exp_x > 608) exp_x = 608;
            checks++;
            if (sprite_x !== 10'(exp_x)) begin
                errors++; $display("FAIL right_frame_%0d got %0d want %0d", i, sprite_x, exp_x);
            end
        end
        btn_right = 1'b0;
        run_frame();
        checks++; if (sprite_x !== 10'd608) begin errors++; $display("FAIL right_saturated got %0d want 608", sprite_x); end
    endtask

    task automatic test_left_clamp();
        do_reset();
        btn_left = 1'b1;
        run_frame();
        checks++; if (b_sprite_x !== 10'd0) begin errors++; $display("FAIL left_clamp_first got %0d want 0", b_sprite_x); end
        checks++; if (sprite_x !== 10'd300) begin errors++; $display("FAIL left_first got %0d want 300", sprite_x); end
        for (int i = 0; i < 50; i++) begin
            run_frame();
            checks++;
            if (b_sprite_x !== 10'd0) begin errors++; $display("FAIL left_clamp_hold_%0d got %0d want 0", i, b_sprite_x); end
        end
        checks++; if (sprite_x !== 10'd100) begin errors++; $display("FAIL left_51_frames got %0d want 100", sprite_x); end
        btn_right = 1'b1;
        for (int i = 0; i < 3; i++) run_frame();
        checks++; if (sprite_x !== 10'd100) begin errors++; $display("FAIL both_hold got %0d want 100", sprite_x); end
        checks++; if (b_sprite_x !== 10'd0) begin errors++; $display("FAIL both_hold_b got %0d want 0", b_sprite_x); end
        btn_left = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic test_single_shot();
        int waited;
        btn_fire = 1'b1;
        vsync = 1'b0;
        waited = 0;
        while (fire_req !== 1'b1 && waited < 12) begin
            step(1);
            waited++;
        end
        btn_fire = 1'b0;
        vsync = 1'b1;
        checks++; if (fire_req !== 1'b1) begin errors++; $display("FAIL shot_req_timeout got %b want 1", fire_req); end
        checks++; if (shot_x !== 10'd116) begin errors++; $display("FAIL shot_x got %0d want 116", shot_x); end
        checks++; if (shot_y !== 10'd447) begin errors++; $display("FAIL shot_y got %0d want 447", shot_y); end
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (fire_req !== 1'b1 || shot_x !== 10'd116 || shot_y !== 10'd447) begin
                errors++; $display("FAIL shot_hold_%0d got req=%b x=%0d y=%0d want 1,116,447", i, fire_req, shot_x, shot_y);
            end
        end
        fire_ack = 1'b1;
        step(1);
        fire_ack = 1'b0;
        checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL shot_ack_drop got %b want 0", fire_req); end
        run_frame();
        checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL shot_no_refire got %b want 0", fire_req); end
    endtask

    task automatic test_autofire();
        int reqs[$];
        do_reset();
        btn_fire = 1'b1;
        for (int f = 0; f < 50; f++) begin
            for (int c = 0; c < 8; c++) begin
                vsync = (c < 4) ? 1'b0 : 1'b1;
                step(1);
                if (fire_req === 1'b1 && fire_ack === 1'b0) begin
                    reqs.push_back(f);
                    fire_ack = 1'b1;
                end else begin
                    fire_ack = 1'b0;
                end
            end
        end
        btn_fire = 1'b0;
        fire_ack = 1'b0;
        checks++;
        if (reqs.size() != 4) begin
            errors++; $display("FAIL autofire_count got %0d want 4", reqs.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (reqs[i] - reqs[i-1] != 16) begin
                    errors++; $display("FAIL autofire_gap_%0d got %0d want 16", i, reqs[i] - reqs[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_in_req();
        int waited;
        do_reset();
        btn_fire = 1'b1;
        btn_right = 1'b1;
        step(2);
        vsync = 1'b0;
        waited = 0;
        while (fire_req !== 1'b1 && waited < 12) begin
            step(1);
            waited++;
        end
        btn_fire = 1'b0;
        vsync = 1'b1;
        step(2);
        checks++; if (fire_req !== 1'b1) begin errors++; $display("FAIL rst_req_setup got %b want 1", fire_req); end
        checks++; if (sprite_x !== 10'd308) begin errors++; $display("FAIL move_during_req got %0d want 308", sprite_x); end
        reset = 1'b0;
        step(1);
        checks++; if (fire_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop got %b want 0", fire_req); end
        checks++; if (u_dut.state_r !== FIRE_IDLE) begin errors++; $display("FAIL rst_req_state got %0d want %0d", u_dut.state_r, FIRE_IDLE); end
        checks++; if (sprite_x !== 10'd304) begin errors++; $display("FAIL rst_req_sprite_x got %0d want 304", sprite_x); end
        reset = 1'b1;
        btn_right = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b0; vsync = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; fire_ack = 1'b0;
        test_reset();
        test_frame_tick();
        test_right_saturate();
        test_left_clamp();
        test_single_shot();
        test_autofire();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
